branch_predictor: RTL and testbench
===================================

# branch_predictor

Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry. It sits in the fetch stage, directly upstream of the PC-select 2:1 mux. Each cycle it looks up the fetch PC and drives `pred_taken` as the mux select and `pred_target` as the taken-path input. The execute stage writes resolved branch outcomes back into it.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `ENTRIES`, 16: number of BTB entries; must be a power of two, range 2–256.

Derived: `IDX = log2(ENTRIES)`, `TAGW = XLEN - IDX - 2`.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `if_pc`  in  XLEN  fetch-stage PC to look up.
- `pred_hit`  out  1  `if_pc` matches a valid entry.
- `pred_taken`  out  1  predicted taken; this is the PC-mux select.
- `pred_target`  out  XLEN  predicted target; 0 when `pred_hit` = 0.
- `upd_valid`  in  1  resolved branch or jump present this cycle.
- `upd_pc`  in  XLEN  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  XLEN  actual target address.
- `upd_mispredict`  in  1  EX detected a misprediction; used only by the statistics feature.

## Operation
- Index = `pc[IDX+1:2]`. Tag = `pc[XLEN-1:IDX+2]`. `pc[1:0]` is ignored.
- Each entry holds `valid`, `tag[TAGW]`, `target[XLEN]` and `ctr[2]`.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is purely combinational from registered state:
  - `pred_hit = valid[i] & (tag[i] == if_pc tag)`.
  - `pred_taken = pred_hit & ctr[i][1]`.
  - `pred_target = pred_hit ? target[i] : 0`.
- Update happens on a `clk` edge with `upd_valid` = 1, indexing by `upd_pc`:
  - **Hit, taken:** `ctr` increments, saturating at ST; `target` is overwritten with `upd_target`.
  - **Hit, not taken:** `ctr` decrements, saturating at SNT; `target` is unchanged.
  - **Miss, taken:** the entry is allocated or replaced with `valid`=1, `tag`=`upd_pc` tag, `target`=`upd_target`, `ctr`=WT.
  - **Miss, not taken:** no state change.
- With `upd_valid` = 0, no entry changes.
- Reset (`rst_n`=0 at an edge):
  - All `valid` = 0, all `ctr` = WNT, all `target` = 0, all `tag` = 0.
  - Outputs therefore read `pred_hit`=0, `pred_taken`=0, `pred_target`=0 from the first cycle after reset.
- Reset has priority over a simultaneous update; the update is discarded.
- Reset asserted mid-operation discards all learned state in one cycle. No multi-cycle clear sequence exists.

## Timing
- Lookup latency: 0 cycles (combinational from `if_pc` to the outputs).
- Update latency: 1 cycle. A write at edge N is visible to lookups from edge N onward, i.e. in the cycle after `upd_valid`.
- Simultaneous lookup and update of the same index in one cycle: the lookup returns pre-update state. There is no bypass.
- Only one update is accepted per cycle. There is no handshake or backpressure; `upd_valid` is always accepted.
- Aliasing: two PCs with equal index and different tag evict each other on a taken miss.
- Tag compare covers the full tag. A PC differing only in `pc[1:0]` hits the same entry.

## Configuration
- Macro: `BP_STATS_EN`.
- **Defined:**
  - Adds outputs `stat_updates` (32-bit) and `stat_mispredicts` (32-bit).
  - `stat_updates` increments on every edge with `upd_valid`=1.
  - `stat_mispredicts` increments on every edge with `upd_valid`=1 and `upd_mispredict`=1.
  - Both counters wrap from 0xFFFFFFFF to 0 and reset to 0 on `rst_n`=0.
- **Undefined:** the ports and counters do not exist, and `upd_mispredict` is ignored.

## Test plan
1. **Reset:** hold `rst_n`=0 for 2 cycles, release, sweep `if_pc` over 0x0–0x3C → `pred_hit`=0, `pred_taken`=0, `pred_target`=0 for every PC.
2. **Allocate:** update `upd_pc`=0x40, `upd_taken`=1, `upd_target`=0x100 → next cycle `if_pc`=0x40 gives `pred_hit`=1, `pred_taken`=1, `pred_target`=0x100.
3. **Saturation:**
   - From the entry of scenario 2, apply not-taken updates one at a time:
     - After the 1st not-taken update, `pred_taken`=0 (WT→WNT).
     - After 2 further not-taken updates, the counter stays at SNT.
   - Then apply 2 taken updates → `pred_taken`=1 only after the 2nd.
4. **Aliasing, ENTRIES=16:**
   - Allocate 0x40 (target 0x100), then a taken update at 0x80 (target 0x200). 0x80 has the same index as 0x40.
   - Result: 0x40 gives `pred_hit`=0; 0x80 gives `pred_hit`=1 with target 0x200.
   - A not-taken miss update at 0x40 leaves the 0x80 entry intact.
5. **Same-cycle:** with `if_pc`=0x200 and a taken update at 0x200 in the same cycle → `pred_hit`=0 that cycle, `pred_hit`=1 the next cycle.
6. **Reset priority / stats (`BP_STATS_EN` defined):**
   - Assert `rst_n`=0 together with a taken update at 0x300 → 0x300 misses afterwards.
   - Then apply 3 updates, 1 with `upd_mispredict`=1 → `stat_updates`=3, `stat_mispredicts`=1.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Optional update/mispredict statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
`ifdef BP_STATS_EN
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts,
`endif
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic            valid_q  [ENTRIES];
    logic            valid_d  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [TAGW-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [XLEN-1:0] target_d [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];
    logic [1:0]      ctr_d    [ENTRIES];

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [IDX-1:0]  up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;

    // Byte offset within a word never takes part in indexing or tagging.
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {if_pc[1:0], upd_pc[1:0]};

    assign lk_idx = if_pc[IDX+1:2];
    assign lk_tag = if_pc[XLEN-1:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && ctr_q[lk_idx][1];
        pred_target = pred_hit ? target_q[lk_idx] : '0;
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != CTR_ST) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    target_d[up_idx] = upd_target;
                end else if (ctr_q[up_idx] != CTR_SNT) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_updates_q;
    logic [31:0] stat_updates_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    // Both counters wrap naturally at 32 bits.
    always_comb begin
        stat_updates_d     = stat_updates_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_valid) begin
            stat_updates_d = stat_updates_q + 32'd1;
            if (upd_mispredict) begin
                stat_mispredicts_d = stat_mispredicts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_updates_q     <= stat_updates_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_updates     = stat_updates_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, XLEN=32).
// Statistics checks are compiled in when BP_STATS_EN is defined.
module tb_branch_predictor;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] if_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_mispredict;
`ifdef BP_STATS_EN
    logic [31:0]     stat_updates;
    logic [31:0]     stat_mispredicts;
`endif

    int checks;
    int errors;

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
`ifdef BP_STATS_EN
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts),
`endif
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // One update across exactly one rising edge; returns at the following falling edge.
    task automatic drive_update(input logic [XLEN-1:0] pc, input logic taken,
                                input logic [XLEN-1:0] target, input logic mis);
        @(negedge clk);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = target;
        upd_mispredict = mis;
        @(negedge clk);
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic set_lookup(input logic [XLEN-1:0] pc);
        if_pc = pc;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int pc = 0; pc <= 'h3C; pc += 4) begin
            @(negedge clk);
            set_lookup(pc);
            checks++;
            if (pred_hit !== 1'b0) begin
                errors++;
                $display("FAIL reset_hit pc=%h got %b expected 0", pc, pred_hit);
            end
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL reset_taken pc=%h got %b expected 0", pc, pred_taken);
            end
            checks++;
            if (pred_target !== 32'h0) begin
                errors++;
                $display("FAIL reset_target pc=%h got %h expected 0", pc, pred_target);
            end
        end
    endtask

    task automatic test_idle_no_write();
        // Taken-looking fields with upd_valid low must not allocate.
        @(negedge clk);
        upd_valid  = 1'b0;
        upd_pc     = 32'h44;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        @(negedge clk);
        set_lookup(32'h44);
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_alloc got %b expected 0", pred_hit);
        end
    endtask

    task automatic test_allocate();
        drive_update(32'h40, 1'b1, 32'h100, 1'b0);
        set_lookup(32'h40);
        checks++;
        if (pred_hit !== 1'b1) begin
            errors++;
            $display("FAIL alloc_hit got %b expected 1", pred_hit);
        end
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL alloc_taken got %b expected 1", pred_taken);
        end
        checks++;
        if (pred_target !== 32'h100) begin
            errors++;
            $display("FAIL alloc_target got %h expected 00000100", pred_target);
        end
        set_lookup(32'h43);
        checks++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h100) begin
            errors++;
            $display("FAIL alloc_low_bits hit=%b target=%h expected hit=1 target=00000100",
                     pred_hit, pred_target);
        end
    endtask

    task automatic test_saturation();
        logic exp_taken [9];
        logic nt_seq    [9];
        // Start WT. NT->WNT, NT->SNT, NT stays SNT, T->WNT, T->WT, T->ST, T stays ST,
        // NT->WT, NT->WNT.
        nt_seq    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_taken = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        set_lookup(32'h40);
        for (int s = 0; s < 9; s++) begin
            // Not-taken updates carry a bogus target that must not be stored.
            if (nt_seq[s]) drive_update(32'h40, 1'b0, 32'hDEAD_0000, 1'b1);
            else           drive_update(32'h40, 1'b1, 32'h104, 1'b0);
            set_lookup(32'h40);
            checks++;
            if (pred_taken !== exp_taken[s] || pred_hit !== 1'b1) begin
                errors++;
                $display("FAIL sat_step%0d taken=%b hit=%b expected taken=%b hit=1",
                         s, pred_taken, pred_hit, exp_taken[s]);
            end
            checks++;
            if (pred_target !== ((s < 3) ? 32'h100 : 32'h104)) begin
                errors++;
                $display("FAIL sat_target_step%0d got %h expected %h", s, pred_target,
                         (s < 3) ? 32'h100 : 32'h104);
            end
        end
    endtask

    task automatic test_aliasing();
        drive_update(32'h40, 1'b1, 32'h100, 1'b0);
        drive_update(32'h80, 1'b1, 32'h200, 1'b0);
        set_lookup(32'h40);
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h0) begin
            errors++;
            $display("FAIL alias_evicted hit=%b target=%h expected hit=0 target=0",
                     pred_hit, pred_target);
        end
        set_lookup(32'h80);
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            errors++;
            $display("FAIL alias_new hit=%b taken=%b target=%h expected 1 1 00000200",
                     pred_hit, pred_taken, pred_target);
        end
        drive_update(32'h40, 1'b0, 32'h999, 1'b0);
        set_lookup(32'h80);
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            errors++;
            $display("FAIL alias_nt_miss_kept hit=%b taken=%b target=%h expected 1 1 00000200",
                     pred_hit, pred_taken, pred_target);
        end
        set_lookup(32'h40);
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL alias_nt_miss_no_alloc got %b expected 0", pred_hit);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        if_pc      = 32'h200;
        upd_valid  = 1'b1;
        upd_pc     = 32'h200;
        upd_taken  = 1'b1;
        upd_target = 32'h280;
        #1;
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_before got %b expected 0", pred_hit);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        checks++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h280) begin
            errors++;
            $display("FAIL same_cycle_after hit=%b taken=%b target=%h expected 1 1 00000280",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst_n      = 1'b0;
        upd_valid  = 1'b1;
        upd_pc     = 32'h300;
        upd_taken  = 1'b1;
        upd_target = 32'h400;
        @(negedge clk);
        rst_n     = 1'b1;
        upd_valid = 1'b0;
        set_lookup(32'h300);
        checks++;
        if (pred_hit !== 1'b0 || pred_target !== 32'h0) begin
            errors++;
            $display("FAIL rst_prio_upd hit=%b target=%h expected hit=0 target=0",
                     pred_hit, pred_target);
        end
        set_lookup(32'h200);
        checks++;
        if (pred_hit !== 1'b0) begin
            errors++;
            $display("FAIL rst_clears_learned got %b expected 0", pred_hit);
        end
`ifdef BP_STATS_EN
        checks++;
        if (stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL stats_after_reset upd=%0d mis=%0d expected 0 0",
                     stat_updates, stat_mispredicts);
        end
        drive_update(32'h300, 1'b1, 32'h400, 1'b0);
        drive_update(32'h300, 1'b0, 32'h400, 1'b1);
        drive_update(32'h304, 1'b0, 32'h0,   1'b0);
        #1;
        checks++;
        if (stat_updates !== 32'd3) begin
            errors++;
            $display("FAIL stat_updates got %0d expected 3", stat_updates);
        end
        checks++;
        if (stat_mispredicts !== 32'd1) begin
            errors++;
            $display("FAIL stat_mispredicts got %0d expected 1", stat_mispredicts);
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        if_pc          = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = 1'b0;

        test_reset();
        test_idle_no_write();
        test_allocate();
        test_saturation();
        test_aliasing();
        test_same_cycle();
        test_reset_priority();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
